sdp_rdma_rd_arb: RTL and testbench



---
 rtl/sdp_rdma_rd_arb_pkg.sv | 26 ++
 rtl/sdp_rdma_ctx_fifo.sv | 47 ++++
 rtl/sdp_rdma_rd_arb.sv | 120 ++++++++++++
 tb/tb_sdp_rdma_rd_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_rdma_rd_arb_pkg.sv
// Shared SDP RDMA read-arbiter definitions: client indices, request field
// positions and the in-order context entry layout.
package sdp_rdma_rd_arb_pkg;

    localparam int NUM_CL = 4;

    localparam logic [1:0] MRDMA = 2'd0;
    localparam logic [1:0] BRDMA = 2'd1;
    localparam logic [1:0] NRDMA = 2'd2;
    localparam logic [1:0] ERDMA = 2'd3;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 63;
    localparam int SIZE_LSB = 64;
    localparam int SIZE_MSB = 78;

    localparam int CTX_W = 18;

    // beats holds the request size, i.e. number of response beats minus one
    typedef struct packed {
        logic [1:0]  id;
        logic        ram_type;
        logic [14:0] beats;
    } ctx_entry_t;

endpackage

// File: rtl/sdp_rdma_ctx_fifo.sv
// Flop-based synchronous FIFO holding the issue-order context of accepted
// read requests. Pointers carry one extra wrap bit to tell full from empty.
module sdp_rdma_ctx_fifo
    import sdp_rdma_rd_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = CTX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // storage is data only; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sdp_rdma_rd_arb.sv
// Round-robin arbiter sharing one SDP RDMA dmaif read port among four clients,
// with in-order response routing driven by a context FIFO.
module sdp_rdma_rd_arb
    import sdp_rdma_rd_arb_pkg::*;
#(
    parameter int REQ_W     = 79,
    parameter int RSP_W     = 514,
    parameter int ORD_DEPTH = 8
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic [NUM_CL-1:0]         cl_req_vld,
    output logic [NUM_CL-1:0]         cl_req_rdy,
    input  logic [NUM_CL*REQ_W-1:0]   cl_req_pd,
    input  logic [NUM_CL-1:0]         cl_req_ram_type,
    output logic [NUM_CL-1:0]         cl_rsp_vld,
    input  logic [NUM_CL-1:0]         cl_rsp_rdy,
    output logic [RSP_W-1:0]          cl_rsp_pd,
    input  logic [NUM_CL-1:0]         cl_cdt_lat_fifo_pop,
    output logic                      dma_rd_req_vld,
    input  logic                      dma_rd_req_rdy,
    output logic [REQ_W-1:0]          dma_rd_req_pd,
    output logic                      dma_rd_req_ram_type,
    input  logic                      dma_rd_rsp_vld,
    output logic                      dma_rd_rsp_rdy,
    input  logic [RSP_W-1:0]          dma_rd_rsp_pd,
    output logic                      dma_rd_rsp_ram_type,
    output logic                      dma_rd_cdt_lat_fifo_pop,
    output logic                      arb_idle
);

    logic [1:0]       rr_ptr;
    logic [1:0]       lock_id;
    logic             lock;
    logic [1:0]       scan_id;
    logic             scan_hit;
    logic [1:0]       grant;
    logic             any_vld;
    logic             req_acc;
    logic             rsp_acc;
    logic             ctx_pop;
    logic             ctx_full;
    logic             ctx_empty;
    logic [14:0]      beat_cnt;
    ctx_entry_t       push_ent;
    ctx_entry_t       head;
    logic [CTX_W-1:0] head_raw;

    always_comb begin
        scan_id  = rr_ptr;
        scan_hit = 1'b0;
        for (int k = 0; k < NUM_CL; k++) begin
            if (!scan_hit && cl_req_vld[rr_ptr + 2'(k)]) begin
                scan_id  = rr_ptr + 2'(k);
                scan_hit = 1'b1;
            end
        end
    end

    // a stalled request keeps its grant so the payload cannot switch clients
    assign grant               = lock ? lock_id : scan_id;
    assign any_vld             = |cl_req_vld;
    assign dma_rd_req_vld      = any_vld & ~ctx_full;
    assign req_acc             = dma_rd_req_vld & dma_rd_req_rdy;
    assign cl_req_rdy          = req_acc ? (4'b0001 << grant) : 4'b0000;
    assign dma_rd_req_pd       = cl_req_pd[grant*REQ_W +: REQ_W];
    assign dma_rd_req_ram_type = cl_req_ram_type[grant];

    assign push_ent = '{id: grant, ram_type: cl_req_ram_type[grant],
                        beats: dma_rd_req_pd[SIZE_MSB:SIZE_LSB]};

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rr_ptr  <= MRDMA;
            lock    <= 1'b0;
            lock_id <= MRDMA;
        end else if (req_acc) begin
            rr_ptr  <= grant + 2'd1;
            lock    <= 1'b0;
        end else if (dma_rd_req_vld) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    sdp_rdma_ctx_fifo #(
        .DEPTH (ORD_DEPTH),
        .W     (CTX_W)
    ) u_ctx_fifo (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (req_acc),
        .push_data (push_ent),
        .pop       (ctx_pop),
        .head      (head_raw),
        .full      (ctx_full),
        .empty     (ctx_empty)
    );

    assign head = ctx_entry_t'(head_raw);

    // an empty FIFO parks the dmaif response select on mcif
    assign dma_rd_rsp_ram_type = ctx_empty ? 1'b1 : head.ram_type;
    assign cl_rsp_vld          = (dma_rd_rsp_vld & ~ctx_empty) ? (4'b0001 << head.id) : 4'b0000;
    assign dma_rd_rsp_rdy      = cl_rsp_rdy[head.id] & ~ctx_empty;
    assign cl_rsp_pd           = dma_rd_rsp_pd;
    assign rsp_acc             = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    assign ctx_pop             = rsp_acc & (beat_cnt == head.beats);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            beat_cnt <= '0;
        else if (rsp_acc)
            beat_cnt <= ctx_pop ? 15'd0 : beat_cnt + 15'd1;
    end

    assign dma_rd_cdt_lat_fifo_pop = |cl_cdt_lat_fifo_pop;
    assign arb_idle                = ctx_empty & ~any_vld & ~lock;

endmodule

// File: tb/tb_sdp_rdma_rd_arb.sv
// Bench for sdp_rdma_rd_arb: cycle table, directed corner sequences and a
// randomized run against a queue-based transaction model.
module tb_sdp_rdma_rd_arb;

    localparam int REQ_W = 79;
    localparam int RSP_W = 514;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic [3:0]         cl_req_vld;
    logic [3:0]         cl_req_rdy;
    logic [REQ_W-1:0]   c_pd [4];
    logic [4*REQ_W-1:0] cl_req_pd;
    logic [3:0]         cl_req_ram_type;
    logic [3:0]         cl_rsp_vld;
    logic [3:0]         cl_rsp_rdy;
    logic [RSP_W-1:0]   cl_rsp_pd;
    logic [3:0]         cdt_pop;
    logic               req_vld, req_rdy, req_rt;
    logic [REQ_W-1:0]   req_pd;
    logic               rsp_vld, rsp_rdy, rsp_rt;
    logic [RSP_W-1:0]   rsp_pd;
    logic               cdt_out, idle;

    always #5 clk = ~clk;

    assign cl_req_pd = {c_pd[3], c_pd[2], c_pd[1], c_pd[0]};

    sdp_rdma_rd_arb #(.REQ_W(REQ_W), .RSP_W(RSP_W), .ORD_DEPTH(DEPTH)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .cl_req_vld              (cl_req_vld),
        .cl_req_rdy              (cl_req_rdy),
        .cl_req_pd               (cl_req_pd),
        .cl_req_ram_type         (cl_req_ram_type),
        .cl_rsp_vld              (cl_rsp_vld),
        .cl_rsp_rdy              (cl_rsp_rdy),
        .cl_rsp_pd               (cl_rsp_pd),
        .cl_cdt_lat_fifo_pop     (cdt_pop),
        .dma_rd_req_vld          (req_vld),
        .dma_rd_req_rdy          (req_rdy),
        .dma_rd_req_pd           (req_pd),
        .dma_rd_req_ram_type     (req_rt),
        .dma_rd_rsp_vld          (rsp_vld),
        .dma_rd_rsp_rdy          (rsp_rdy),
        .dma_rd_rsp_pd           (rsp_pd),
        .dma_rd_rsp_ram_type     (rsp_rt),
        .dma_rd_cdt_lat_fifo_pop (cdt_out),
        .arb_idle                (idle)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] make_pd(int id, int size, logic [31:0] tag);
        return {15'(size), 32'hA000_0000 | 32'(id), tag};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_rsp_pd();
        for (int w = 0; w < 16; w++) rsp_pd[w*32 +: 32] = $urandom;
        rsp_pd[513:512] = 2'($urandom);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cl_req_vld = '0; req_rdy = 1'b0; rsp_vld = 1'b0; cl_rsp_rdy = 4'hF; cdt_pop = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic       rspv;
        logic       e_vld;
        logic [3:0] e_crdy;
        int         e_grant;
        logic [3:0] e_rspv;
        logic       e_rsprdy;
        logic       e_rt;
        logic       e_idle;
    } vec_t;

    function automatic vec_t v(logic [3:0] vld, logic rdy, logic rspv, logic ev, logic [3:0] ecr,
                               int eg, logic [3:0] erv, logic err, logic ert, logic eid);
        vec_t r;
        r.vld = vld; r.rdy = rdy; r.rspv = rspv; r.e_vld = ev; r.e_crdy = ecr; r.e_grant = eg;
        r.e_rspv = erv; r.e_rsprdy = err; r.e_rt = ert; r.e_idle = eid;
        return r;
    endfunction

    typedef struct {
        int id;
        bit rt;
        int left;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   m_rr, m_lock_id;
    bit   m_lock;
    bit   hold [4];

    initial begin
        c_pd[0] = '0; c_pd[1] = '0; c_pd[2] = '0; c_pd[3] = '0;
        cl_req_ram_type = 4'b1010;
        rsp_pd = '0;
        do_reset();

        // cycle table: round-robin, lock under stall, then in-order drain
        tbl.push_back(v(4'b0000,0,0, 0,4'b0000,-1, 4'b0000,0,1,1));
        tbl.push_back(v(4'b1111,1,0, 1,4'b0001, 0, 4'b0000,0,1,0));
        tbl.push_back(v(4'b1111,1,0, 1,4'b0010, 1, 4'b0000,1,0,0));
        tbl.push_back(v(4'b1111,1,0, 1,4'b0100, 2, 4'b0000,1,0,0));
        tbl.push_back(v(4'b1111,1,0, 1,4'b1000, 3, 4'b0000,1,0,0));
        tbl.push_back(v(4'b1111,1,0, 1,4'b0001, 0, 4'b0000,1,0,0));
        tbl.push_back(v(4'b0100,0,0, 1,4'b0000, 2, 4'b0000,1,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(4'b0110,0,0, 1,4'b0000, 2, 4'b0000,1,0,0));
        tbl.push_back(v(4'b0110,1,0, 1,4'b0100, 2, 4'b0000,1,0,0));
        tbl.push_back(v(4'b0010,1,0, 1,4'b0010, 1, 4'b0000,1,0,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0001,1,0,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0010,1,1,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0100,1,0,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b1000,1,1,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0001,1,0,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0100,1,0,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0010,1,1,0));
        tbl.push_back(v(4'b0000,0,1, 0,4'b0000,-1, 4'b0000,0,1,1));

        for (int i = 0; i < 4; i++) c_pd[i] = make_pd(i, 0, 32'h100 + 32'(i));
        foreach (tbl[r]) begin
            cl_req_vld = tbl[r].vld; req_rdy = tbl[r].rdy; rsp_vld = tbl[r].rspv;
            cdt_pop = tbl[r].vld;
            rand_rsp_pd();
            #4;
            chk($sformatf("row%0d req_vld", r), 520'(req_vld), 520'(tbl[r].e_vld));
            chk($sformatf("row%0d cl_req_rdy", r), 520'(cl_req_rdy), 520'(tbl[r].e_crdy));
            if (tbl[r].e_grant >= 0) begin
                chk($sformatf("row%0d req_pd", r), 520'(req_pd), 520'(c_pd[tbl[r].e_grant]));
                chk($sformatf("row%0d req_rt", r), 520'(req_rt),
                    520'(cl_req_ram_type[tbl[r].e_grant]));
            end
            chk($sformatf("row%0d cl_rsp_vld", r), 520'(cl_rsp_vld), 520'(tbl[r].e_rspv));
            chk($sformatf("row%0d rsp_rdy", r), 520'(rsp_rdy), 520'(tbl[r].e_rsprdy));
            chk($sformatf("row%0d rsp_rt", r), 520'(rsp_rt), 520'(tbl[r].e_rt));
            chk($sformatf("row%0d idle", r), 520'(idle), 520'(tbl[r].e_idle));
            chk($sformatf("row%0d rsp_pd", r), 520'(cl_rsp_pd), 520'(rsp_pd));
            chk($sformatf("row%0d cdt_pop", r), 520'(cdt_out), 520'(|tbl[r].vld));
            next_cycle();
        end
        rsp_vld = 1'b0; cdt_pop = '0;

        // multi-beat routing: client 0 size 3, then client 3 size 0
        c_pd[0] = make_pd(0, 3, 32'h300); c_pd[3] = make_pd(3, 0, 32'h303);
        cl_req_vld = 4'b0001; req_rdy = 1'b1; #4;
        chk("mb acc0", 520'(cl_req_rdy), 520'(4'b0001));
        next_cycle();
        cl_req_vld = 4'b1000; #4;
        chk("mb acc3", 520'(cl_req_rdy), 520'(4'b1000));
        next_cycle();
        cl_req_vld = 4'b0000; rsp_vld = 1'b1;
        for (int b = 0; b < 5; b++) begin
            rand_rsp_pd(); #4;
            chk($sformatf("mb beat%0d vld", b), 520'(cl_rsp_vld), 520'(b < 4 ? 4'b0001 : 4'b1000));
            chk($sformatf("mb beat%0d rt", b), 520'(rsp_rt), 520'(b < 4 ? 1'b0 : 1'b1));
            chk($sformatf("mb beat%0d pd", b), 520'(cl_rsp_pd), 520'(rsp_pd));
            next_cycle();
        end
        #4;
        chk("mb empty vld", 520'(cl_rsp_vld), 520'(4'b0000));
        chk("mb empty rdy", 520'(rsp_rdy), 520'(1'b0));
        chk("mb idle", 520'(idle), 520'(1'b1));
        next_cycle();
        rsp_vld = 1'b0;

        // ram type ordering and response backpressure
        c_pd[1] = make_pd(1, 1, 32'h501); c_pd[2] = make_pd(2, 0, 32'h502);
        cl_req_vld = 4'b0010; #4;
        chk("rt acc1", 520'(cl_req_rdy), 520'(4'b0010));
        next_cycle();
        cl_req_vld = 4'b0100; #4;
        chk("rt acc2", 520'(cl_req_rdy), 520'(4'b0100));
        next_cycle();
        cl_req_vld = 4'b0000; rsp_vld = 1'b1; cl_rsp_rdy = 4'b1101;
        for (int s = 0; s < 2; s++) begin
            #4;
            chk("bp rsp_rdy", 520'(rsp_rdy), 520'(1'b0));
            chk("bp cl_rsp_vld", 520'(cl_rsp_vld), 520'(4'b0010));
            chk("bp rt", 520'(rsp_rt), 520'(1'b1));
            next_cycle();
        end
        cl_rsp_rdy = 4'b1111;
        for (int b = 0; b < 3; b++) begin
            #4;
            chk($sformatf("rt beat%0d rt", b), 520'(rsp_rt), 520'(b < 2 ? 1'b1 : 1'b0));
            chk($sformatf("rt beat%0d vld", b), 520'(cl_rsp_vld), 520'(b < 2 ? 4'b0010 : 4'b0100));
            next_cycle();
        end
        rsp_vld = 1'b0; #4;
        chk("rt empty", 520'(rsp_rt), 520'(1'b1));
        next_cycle();

        // full FIFO: eight single-beat requests, then blocked until one pop
        c_pd[0] = make_pd(0, 0, 32'h400);
        cl_req_vld = 4'b0001; req_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk($sformatf("full acc%0d", k), 520'(cl_req_rdy), 520'(4'b0001));
            next_cycle();
        end
        rsp_vld = 1'b1; #4;
        chk("full req_vld", 520'(req_vld), 520'(1'b0));
        chk("full cl_req_rdy", 520'(cl_req_rdy), 520'(4'b0000));
        next_cycle();
        rsp_vld = 1'b0; #4;
        chk("full reopen vld", 520'(req_vld), 520'(1'b1));
        chk("full reopen rdy", 520'(cl_req_rdy), 520'(4'b0001));
        next_cycle();
        cl_req_vld = 4'b0000; rsp_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("full drain", 520'(cl_rsp_vld), 520'(4'b0001));
            next_cycle();
        end
        rsp_vld = 1'b0; #4;
        chk("full idle", 520'(idle), 520'(1'b1));
        next_cycle();

        // reset in the middle of a 4-beat burst
        c_pd[0] = make_pd(0, 3, 32'h600);
        cl_req_vld = 4'b0001; #4;
        chk("rst acc", 520'(cl_req_rdy), 520'(4'b0001));
        next_cycle();
        cl_req_vld = 4'b0000; rsp_vld = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #4;
            chk("rst beat", 520'(cl_rsp_vld), 520'(4'b0001));
            next_cycle();
        end
        #2 rstn = 1'b0;
        #1;
        chk("rst req_vld", 520'(req_vld), 520'(1'b0));
        chk("rst cl_req_rdy", 520'(cl_req_rdy), 520'(4'b0000));
        chk("rst cl_rsp_vld", 520'(cl_rsp_vld), 520'(4'b0000));
        chk("rst rsp_rdy", 520'(rsp_rdy), 520'(1'b0));
        chk("rst rsp_rt", 520'(rsp_rt), 520'(1'b1));
        chk("rst idle", 520'(idle), 520'(1'b1));
        rsp_vld = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        cl_req_vld = 4'b1111; #4;
        chk("rst rr_ptr", 520'(cl_req_rdy), 520'(4'b0001));
        next_cycle();

        // randomized traffic against the transaction model
        do_reset();
        mq.delete(); m_rr = 0; m_lock = 0; m_lock_id = 0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  g;
            bit  found, full, e_vld, e_acc, e_rr, e_rt, e_idle;
            logic [3:0] e_crdy, e_rv;
            for (int i = 0; i < 4; i++) begin
                if (!hold[i] && $urandom_range(0, 2) == 0) begin
                    hold[i] = 1;
                    c_pd[i] = make_pd(i, int'($urandom_range(0, 3)), $urandom);
                    cl_req_ram_type[i] = 1'($urandom);
                end
                cl_req_vld[i] = hold[i];
            end
            req_rdy    = ($urandom_range(0, 3) != 0);
            rsp_vld    = 1'($urandom);
            for (int i = 0; i < 4; i++) cl_rsp_rdy[i] = ($urandom_range(0, 3) != 0);
            cdt_pop    = 4'($urandom);
            rand_rsp_pd();
            #4;
            full = (mq.size() == DEPTH);
            g = 0; found = 0;
            if (m_lock) begin
                g = m_lock_id; found = 1;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (!found && cl_req_vld[(m_rr + k) % 4]) begin
                        g = (m_rr + k) % 4; found = 1;
                    end
            end
            e_vld  = (cl_req_vld != 0) && !full;
            e_acc  = e_vld && req_rdy;
            e_crdy = e_acc ? 4'(1 << g) : 4'b0000;
            if (mq.size() == 0) begin
                e_rv = 4'b0000; e_rr = 0; e_rt = 1;
            end else begin
                e_rv = rsp_vld ? 4'(1 << mq[0].id) : 4'b0000;
                e_rr = cl_rsp_rdy[mq[0].id];
                e_rt = mq[0].rt;
            end
            e_idle = (mq.size() == 0) && (cl_req_vld == 0) && !m_lock;
            chk("rnd req_vld", 520'(req_vld), 520'(e_vld));
            chk("rnd cl_req_rdy", 520'(cl_req_rdy), 520'(e_crdy));
            if (e_vld) begin
                chk("rnd req_pd", 520'(req_pd), 520'(c_pd[g]));
                chk("rnd req_rt", 520'(req_rt), 520'(cl_req_ram_type[g]));
            end
            chk("rnd cl_rsp_vld", 520'(cl_rsp_vld), 520'(e_rv));
            chk("rnd rsp_rdy", 520'(rsp_rdy), 520'(e_rr));
            chk("rnd rsp_rt", 520'(rsp_rt), 520'(e_rt));
            chk("rnd rsp_pd", 520'(cl_rsp_pd), 520'(rsp_pd));
            chk("rnd cdt_pop", 520'(cdt_out), 520'(cdt_pop != 0));
            chk("rnd idle", 520'(idle), 520'(e_idle));
            if (mq.size() > 0 && rsp_vld && e_rr) begin
                mq[0].left = mq[0].left - 1;
                if (mq[0].left == 0) void'(mq.pop_front());
            end
            if (e_acc) begin
                ent_t e;
                e.id = g; e.rt = cl_req_ram_type[g]; e.left = int'(c_pd[g][78:64]) + 1;
                mq.push_back(e);
                hold[g] = 0; m_rr = (g + 1) % 4; m_lock = 0;
            end else if (e_vld) begin
                m_lock = 1; m_lock_id = g;
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
